// File: rtl/gate_stimulus_checker.sv
// Stimulus and checker stage for a 2-input AND/NAND gate under test.
// Steps a/b through 00,01,10,11, samples y/yn once per vector and counts failures.
module gate_stimulus_checker #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             y,
    input  logic             yn,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]       SETTLE    = 8'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t     state;
    state_t     state_d;
    logic [1:0] v;
    logic [1:0] v_next;
    logic [7:0] c;
    logic       launch;
    logic       sample;
    logic       advance;
    logic       finish;
    logic       expect_y;
    logic       sample_bad;
    logic       hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        launch  = 1'b0;
        sample  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                sample = (c == SETTLE);
                if (c == HOLD_LAST) begin
                    if (v == 2'd3) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    launch  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // a/b are the registered drive, so the expectation tracks what the gate sees.
    assign expect_y   = a & b;
    assign sample_bad = (y != expect_y) || (yn != ~expect_y);
    assign hit        = sample && sample_bad;
    assign v_next     = v + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v          <= 2'd0;
            c          <= 8'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= 2'd0;
        end else if (launch) begin
            v          <= 2'd0;
            c          <= 8'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= 2'd0;
        end else if (state == RUN) begin
            if (advance) begin
                v <= v_next;
                c <= 8'd0;
                a <= v_next[1];
                b <= v_next[0];
            end else if (!finish) begin
                c <= c + 8'd1;
            end
            if (hit) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 1'b1;
                end
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_idx   <= v;
                end
            end
            // The last sample may land on the finishing edge.
            if (finish) begin
                pass <= (err_count == '0) && !hit;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_gate_stimulus_checker.sv
// Directed bench for gate_stimulus_checker with fault-injecting gate models.
// Three instances: defaults, ERR_W=2 saturation, and a slow gate with long hold.
`timescale 1ns/1ps
module tb_gate_stimulus_checker;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic start3;
    int   mode;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Instance 1: default parameters, selectable fault
    logic a1, b1, y1, yn1, busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [1:0] idx1;

    always_comb begin
        y1  = a1 & b1;
        yn1 = ~(a1 & b1);
        if (mode == 1) y1 = 1'b0;
        if (mode == 2) yn1 = a1 & b1;
    end

    gate_stimulus_checker dut1 (
        .clk(clk), .reset(reset), .start(start),
        .y(y1), .yn(yn1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_idx(idx1)
    );

    // Instance 2: ERR_W=2, both outputs inverted
    logic a2, b2, y2, yn2, busy2, done2, pass2, fv2;
    logic [1:0] err2;
    logic [1:0] idx2;

    assign y2  = ~(a2 & b2);
    assign yn2 = a2 & b2;

    gate_stimulus_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .y(y2), .yn(yn2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_valid(fv2), .fail_idx(idx2)
    );

    // Instance 3: slow gate, 7-clock delay line
    logic a3, b3, busy3, done3, pass3, fv3;
    logic [3:0] err3;
    logic [1:0] idx3;
    logic [6:0] pipe = 7'd0;

    always @(posedge clk) pipe <= {pipe[5:0], a3 & b3};

    gate_stimulus_checker #(.HOLD_CYCLES(8), .SETTLE_CYCLES(7)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .y(pipe[6]), .yn(~pipe[6]), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .fail_idx(idx3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = 0;
        #2;
        check("rst_a", a1, 0);
        check("rst_b", b1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_err", err1, 0);
        check("rst_fv", fv1, 0);
        check("rst_idx", idx1, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Run 1: good gate
        pulse_start();
        check("r1_busy0", busy1, 1);
        check("r1_ab0", {a1, b1}, 2'b00);
        repeat (4) @(posedge clk);
        #1 check("r1_ab1", {a1, b1}, 2'b01);
        repeat (4) @(posedge clk);
        #1 check("r1_ab2", {a1, b1}, 2'b10);
        repeat (4) @(posedge clk);
        #1 check("r1_ab3", {a1, b1}, 2'b11);
        repeat (3) @(posedge clk);
        #1 check("r1_done15", done1, 0);
        check("r1_busy15", busy1, 1);
        @(posedge clk);
        #1 check("r1_done16", done1, 1);
        check("r1_busy16", busy1, 0);
        check("r1_pass", pass1, 1);
        check("r1_err", err1, 0);
        check("r1_fv", fv1, 0);
        check("r1_ab_hold", {a1, b1}, 2'b11);
        check("sat_err", err2, 3);
        check("sat_pass", pass2, 0);
        check("sat_idx", idx2, 0);
        check("sat_done", done2, 1);

        // Run 2: y stuck at 0, restarted from DONE
        mode = 1;
        pulse_start();
        check("r2_done0", done1, 0);
        check("r2_busy0", busy1, 1);
        repeat (16) @(posedge clk);
        #1 check("r2_done", done1, 1);
        check("r2_err", err1, 1);
        check("r2_idx", idx1, 2'b11);
        check("r2_fv", fv1, 1);
        check("r2_pass", pass1, 0);

        // Run 3: yn wired to y, extra start mid-run
        mode = 2;
        pulse_start();
        check("r3_err_clr", err1, 0);
        check("r3_fv_clr", fv1, 0);
        check("r3_done0", done1, 0);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 check("r3_done15", done1, 0);
        @(posedge clk);
        #1 check("r3_done16", done1, 1);
        check("r3_err", err1, 4);
        check("r3_idx", idx1, 2'b00);
        check("r3_pass", pass1, 0);

        // Run 4: async reset at edge 9 plus half a cycle
        pulse_start();
        repeat (9) @(posedge clk);
        #1 check("r4_err_pre", err1, 2);
        check("r4_ab_pre", {a1, b1}, 2'b10);
        #4 reset = 1'b1;
        #1 check("r4_a", a1, 0);
        check("r4_b", b1, 0);
        check("r4_busy", busy1, 0);
        check("r4_err", err1, 0);
        check("r4_fv", fv1, 0);
        check("r4_done", done1, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (18) @(posedge clk);
        #1 check("r4_no_done", done1, 0);
        check("r4_idle", busy1, 0);

        // Run 5: slow gate, long hold, late sample
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        check("r5_busy", busy3, 1);
        repeat (31) @(posedge clk);
        #1 check("r5_done31", done3, 0);
        @(posedge clk);
        #1 check("r5_done32", done3, 1);
        check("r5_pass", pass3, 1);
        check("r5_err", err3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
